// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address and
// registers each returned word into a one-entry valid/ready output stage.
// Branch redirects reload the PC. Misaligned or out-of-range fetch addresses
// park the block in FAULT.
// Optional feature macro: IFETCH_PERF_EN enables the fetch/redirect counters.
module instr_fetch_ctrl #(
    parameter int unsigned MEM_SIZE = 32'd1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] redirect_cnt
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // An address is unusable if it is not word aligned or the word runs past the ROM end.
    function automatic logic is_bad(input logic [63:0] addr);
        logic [63:0] last_byte;
        last_byte = addr + 64'd3;
        return (addr[1:0] != 2'b00) || (last_byte >= MEM_LIMIT);
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [63:0] pc_r;
    logic [63:0] pc_s;
    logic        out_valid_r;
    logic        out_valid_s;
    logic [31:0] out_instr_r;
    logic [63:0] out_pc_r;
    logic [63:0] fault_pc_r;
    logic [63:0] fault_pc_s;
    logic        load_s;
    logic        consume_s;
    logic        slot_free_s;
    logic        pc_bad_s;
    logic        tgt_bad_s;

    assign consume_s   = out_valid_r && out_ready;
    assign slot_free_s = !out_valid_r || out_ready;
    assign pc_bad_s    = is_bad(pc_r);
    assign tgt_bad_s   = is_bad(redirect_pc);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a redirect overrides every state.
    always_comb begin
        state_s = state_r;
        if (redirect_valid) begin
            if (tgt_bad_s) begin
                state_s = ST_FAULT;
            end else if (run) begin
                state_s = ST_FETCH;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!run) begin
                        state_s = ST_IDLE;
                    end else if (slot_free_s && pc_bad_s) begin
                        state_s = ST_FAULT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath control: load decision, next PC, output-stage valid and fault capture.
    always_comb begin
        load_s      = 1'b0;
        pc_s        = pc_r;
        fault_pc_s  = fault_pc_r;
        out_valid_s = consume_s ? 1'b0 : out_valid_r;
        if (redirect_valid) begin
            pc_s        = redirect_pc;
            out_valid_s = 1'b0;
            if (tgt_bad_s) begin
                fault_pc_s = redirect_pc;
            end else begin
                fault_pc_s = fault_pc_r;
            end
        end else if ((state_r == ST_FETCH) && run && slot_free_s) begin
            if (pc_bad_s) begin
                fault_pc_s = pc_r;
            end else begin
                load_s      = 1'b1;
                pc_s        = pc_r + 64'd4;
                out_valid_s = 1'b1;
            end
        end else begin
            pc_s = pc_r;
        end
    end

    // PC, output stage and fault address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_pc_r    <= 64'd0;
            fault_pc_r  <= 64'd0;
        end else begin
            pc_r        <= pc_s;
            out_valid_r <= out_valid_s;
            fault_pc_r  <= fault_pc_s;
            if (load_s) begin
                out_instr_r <= imem_instr;
                out_pc_r    <= pc_r;
            end
        end
    end

    assign imem_addr = pc_r;
    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_pc    = out_pc_r;
    assign fault     = (state_r == ST_FAULT);
    assign fault_pc  = fault_pc_r;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Performance counters: loads and redirect cycles, both free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_r    <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            if (load_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (redirect_valid) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_cnt    = fetch_cnt_r;
    assign redirect_cnt = redirect_cnt_r;
`else
    assign fetch_cnt    = 32'd0;
    assign redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a vector table for the main fetch,
// stall, redirect and fault behaviour, plus hand-written sequences for reset
// during a stall and the performance counters.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    int n_cmp;
    int n_bad;

    instr_fetch_ctrl #(.MEM_SIZE(32'd1024), .RESET_PC(64'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_cnt      (fetch_cnt),
        .redirect_cnt   (redirect_cnt)
    );

    // ROM image: each word tagged with its own address.
    function automatic logic [31:0] rom(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign imem_instr = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        ov;
        logic [63:0] opc;
        logic [63:0] addr;
        logic        flt;
        logic [63:0] fpc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic rv,
                                input logic [63:0] rpc, input logic ov,
                                input logic [63:0] opc, input logic [63:0] addr,
                                input logic flt, input logic [63:0] fpc);
        vec_t v;
        v.run = r; v.rdy = rd; v.rv = rv; v.rpc = rpc; v.ov = ov;
        v.opc = opc; v.addr = addr; v.flt = flt; v.fpc = fpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vq[$];
    logic [31:0] exp_fc;
    logic [31:0] exp_rc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        run = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;

        //        run  rdy  rv   rpc        ov   out_pc     addr       flt  fault_pc
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b0,64'h0,   64'h0,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h0,   64'h4,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h4,   64'h8,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h8,   64'hC,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b0,1'b0,64'h0,   1'b1,64'h8,   64'hC,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b0,1'b0,64'h0,   1'b1,64'h8,   64'hC,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b0,1'b0,64'h0,   1'b1,64'h8,   64'hC,   1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'hC,   64'h10,  1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b1,64'h40,  1'b0,64'hC,   64'h40,  1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h40,  64'h44,  1'b0,64'h0));
        vq.push_back(mk(1'b1,1'b1,1'b1,64'h42,  1'b0,64'h40,  64'h42,  1'b1,64'h42));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b0,64'h40,  64'h42,  1'b1,64'h42));
        vq.push_back(mk(1'b1,1'b1,1'b1,64'h0,   1'b0,64'h40,  64'h0,   1'b0,64'h42));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h0,   64'h4,   1'b0,64'h42));
        vq.push_back(mk(1'b1,1'b1,1'b1,64'h3FE, 1'b0,64'h0,   64'h3FE, 1'b1,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b1,64'h3F0, 1'b0,64'h0,   64'h3F0, 1'b0,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h3F0, 64'h3F4, 1'b0,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h3F4, 64'h3F8, 1'b0,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h3F8, 64'h3FC, 1'b0,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h3FC, 64'h400, 1'b0,64'h3FE));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b0,64'h3FC, 64'h400, 1'b1,64'h400));
        vq.push_back(mk(1'b0,1'b1,1'b1,64'h0,   1'b0,64'h3FC, 64'h0,   1'b0,64'h400));
        vq.push_back(mk(1'b0,1'b1,1'b0,64'h0,   1'b0,64'h3FC, 64'h0,   1'b0,64'h400));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b0,64'h3FC, 64'h0,   1'b0,64'h400));
        vq.push_back(mk(1'b1,1'b1,1'b0,64'h0,   1'b1,64'h0,   64'h4,   1'b0,64'h400));
        vq.push_back(mk(1'b0,1'b0,1'b0,64'h0,   1'b1,64'h0,   64'h4,   1'b0,64'h400));
        vq.push_back(mk(1'b0,1'b1,1'b0,64'h0,   1'b0,64'h0,   64'h4,   1'b0,64'h400));

        // Reset held for two cycles.
        cyc();
        cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_fault_pc", fault_pc, 64'd0);
        chk("rst_fetch_cnt", {32'd0, fetch_cnt}, 64'd0);
        chk("rst_redirect_cnt", {32'd0, redirect_cnt}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            run            = vq[i].run;
            out_ready      = vq[i].rdy;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            cyc();
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vq[i].ov});
            chk($sformatf("v%0d_out_pc", i), out_pc, vq[i].opc);
            chk($sformatf("v%0d_imem_addr", i), imem_addr, vq[i].addr);
            chk($sformatf("v%0d_fault", i), {63'd0, fault}, {63'd0, vq[i].flt});
            chk($sformatf("v%0d_fault_pc", i), fault_pc, vq[i].fpc);
            if (vq[i].ov) begin
                chk($sformatf("v%0d_out_instr", i), {32'd0, out_instr}, {32'd0, rom(vq[i].opc)});
            end
        end
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;

        // Reset arriving during a stall discards the held instruction.
        run = 1'b1;
        out_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_out_pc", out_pc, 64'h4);
        chk("stall_out_instr", {32'd0, out_instr}, {32'd0, rom(64'h4)});
        chk("stall_imem_addr", imem_addr, 64'h8);
        reset = 1'b1;
        cyc();
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_imem_addr", imem_addr, 64'd0);
        chk("midrst_fault", {63'd0, fault}, 64'd0);
        chk("midrst_fetch_cnt", {32'd0, fetch_cnt}, 64'd0);

        // One redirect followed by five loads, then stop.
        reset = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        cyc();
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("run_out_pc%0d", k), out_pc, 64'(4 * k));
        end
        run = 1'b0;
        cyc();
        chk("cnt_out_valid", {63'd0, out_valid}, 64'd0);
        chk("cnt_imem_addr", imem_addr, 64'h14);
`ifdef IFETCH_PERF_EN
        exp_fc = 32'd5;
        exp_rc = 32'd1;
`else
        exp_fc = 32'd0;
        exp_rc = 32'd0;
`endif
        chk("fetch_cnt", {32'd0, fetch_cnt}, {32'd0, exp_fc});
        chk("redirect_cnt", {32'd0, redirect_cnt}, {32'd0, exp_rc});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
